// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and widths for the branch-predictor update path
package bpu_pkg;

  localparam int BTB_DATA_W  = 129;
  localparam int BTB_INDEX_W = 9;
  localparam int BHT_INDEX_W = 9;

  // One buffered training update: BHT counter change plus optional BTB write
  typedef struct packed {
    logic [BHT_INDEX_W-1:0] bht_index;
    logic [1:0]             bht_sel;
    logic                   bht_inc;
    logic                   bht_dec;
    logic                   btb_we;
    logic [BTB_INDEX_W-1:0] btb_index;
    logic [BTB_DATA_W-1:0]  btb_wmask;
    logic [BTB_DATA_W-1:0]  btb_din;
  } bpu_update_t;

endpackage

// File: rtl/bpu_update_arb_sync_fifo.sv
// rtl/bpu_update_arb_sync_fifo.sv - wrap-bit pointer FIFO with a registered-only read path
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bpu_update_arb.sv
// rtl/bpu_update_arb.sv - buffers BHT/BTB training updates and arbitrates the shared BTB port
module bpu_update_arb
  import bpu_pkg::*;
#(
  parameter int DEPTH              = 4,
  parameter int BHTBTB_INDEX_WIDTH = 9,
  parameter int STARVE_LIMIT       = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          upd_bht_en,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] upd_bht_index,
  input  logic [1:0]                    upd_bht_sel,
  input  logic                          upd_bht_inc,
  input  logic                          upd_bht_dec,
  input  logic                          upd_btb_we,
  input  logic [8:0]                    upd_btb_index,
  input  logic [128:0]                  upd_btb_wmask,
  input  logic [128:0]                  upd_btb_din,
  output logic                          upd_ready,
  input  logic                          ifu_btb_rd_req,
  output logic                          ifu_btb_rd_stall,
  output logic                          bht_write_enable,
  output logic [BHTBTB_INDEX_WIDTH-1:0] bht_write_index,
  output logic [1:0]                    bht_write_counter_select,
  output logic                          bht_write_inc,
  output logic                          bht_write_dec,
  output logic                          bht_valid_in,
  output logic                          btb_we,
  output logic [8:0]                    btb_write_index,
  output logic [128:0]                  btb_wmask,
  output logic [128:0]                  btb_din,
  output logic [31:0]                   drop_cnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PORT, FORCE} arb_state_e;

  arb_state_e        state;
  logic [CNT_W-1:0]  starve_cnt;
  bpu_update_t       enq_entry;
  bpu_update_t       head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              issue;
  logic              force_wr;
  logic              head_btb_we;

  always_comb begin
    enq_entry           = '0;
    enq_entry.bht_index = upd_bht_index;
    enq_entry.bht_sel   = upd_bht_sel;
    enq_entry.bht_inc   = upd_bht_inc;
    enq_entry.bht_dec   = upd_bht_dec;
    enq_entry.btb_we    = upd_btb_we;
    enq_entry.btb_index = upd_btb_index;
    enq_entry.btb_wmask = upd_btb_wmask;
    enq_entry.btb_din   = upd_btb_din;
  end

  sync_fifo #(
    .WIDTH($bits(bpu_update_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(enq_entry),
    .pop      (issue),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Fetch reads win the BTB port unless the head has already waited STARVE_LIMIT cycles
  assign force_wr    = (state == FORCE);
  assign head_btb_we = head.btb_we;
  assign issue       = !fifo_empty && (!head_btb_we || !ifu_btb_rd_req || force_wr);
  assign upd_ready   = !fifo_full || issue;
  assign push        = upd_bht_en && upd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (upd_bht_en && !upd_ready) drop_cnt <= drop_cnt + 32'd1;
      if (fifo_empty || issue) begin
        state      <= IDLE;
        starve_cnt <= '0;
      end else if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
        state      <= (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) ? FORCE : WAIT_PORT;
      end
    end
  end

  // Write ports are driven straight from the head; idle fields are held at zero
  assign bht_write_enable         = issue;
  assign bht_valid_in             = issue;
  assign bht_write_index          = issue ? head.bht_index : '0;
  assign bht_write_counter_select = issue ? head.bht_sel   : '0;
  assign bht_write_inc            = issue && head.bht_inc;
  assign bht_write_dec            = issue && head.bht_dec;
  assign btb_we                   = issue && head_btb_we;
  assign btb_write_index          = btb_we ? head.btb_index : '0;
  assign btb_wmask                = btb_we ? head.btb_wmask : '0;
  assign btb_din                  = btb_we ? head.btb_din   : '0;
  assign ifu_btb_rd_stall         = issue && force_wr;

endmodule

// File: tb/tb_bpu_update_arb.sv
// tb/tb_bpu_update_arb.sv - scoreboard bench for bpu_update_arb
module tb_bpu_update_arb;

  typedef logic [131:0] w_t;

  typedef struct {
    logic [8:0]   bidx;
    logic [1:0]   sel;
    logic         inc;
    logic         dec;
    logic         bwe;
    logic [8:0]   tidx;
    logic [128:0] mask;
    logic [128:0] din;
    logic         stall;
    int           cyc;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         upd_bht_en;
  logic [8:0]   upd_bht_index;
  logic [1:0]   upd_bht_sel;
  logic         upd_bht_inc;
  logic         upd_bht_dec;
  logic         upd_btb_we;
  logic [8:0]   upd_btb_index;
  logic [128:0] upd_btb_wmask;
  logic [128:0] upd_btb_din;
  logic         upd_ready;
  logic         ifu_btb_rd_req;
  logic         ifu_btb_rd_stall;
  logic         bht_write_enable;
  logic [8:0]   bht_write_index;
  logic [1:0]   bht_write_counter_select;
  logic         bht_write_inc;
  logic         bht_write_dec;
  logic         bht_valid_in;
  logic         btb_we;
  logic [8:0]   btb_write_index;
  logic [128:0] btb_wmask;
  logic [128:0] btb_din;
  logic [31:0]  drop_cnt;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  exp_t q[$];

  logic [128:0] junk_m;
  logic [128:0] junk_d;
  logic [128:0] m2;
  logic [128:0] d2;

  bpu_update_arb dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .upd_bht_en              (upd_bht_en),
    .upd_bht_index           (upd_bht_index),
    .upd_bht_sel             (upd_bht_sel),
    .upd_bht_inc             (upd_bht_inc),
    .upd_bht_dec             (upd_bht_dec),
    .upd_btb_we              (upd_btb_we),
    .upd_btb_index           (upd_btb_index),
    .upd_btb_wmask           (upd_btb_wmask),
    .upd_btb_din             (upd_btb_din),
    .upd_ready               (upd_ready),
    .ifu_btb_rd_req          (ifu_btb_rd_req),
    .ifu_btb_rd_stall        (ifu_btb_rd_stall),
    .bht_write_enable        (bht_write_enable),
    .bht_write_index         (bht_write_index),
    .bht_write_counter_select(bht_write_counter_select),
    .bht_write_inc           (bht_write_inc),
    .bht_write_dec           (bht_write_dec),
    .bht_valid_in            (bht_valid_in),
    .btb_we                  (btb_we),
    .btb_write_index         (btb_write_index),
    .btb_wmask               (btb_wmask),
    .btb_din                 (btb_din),
    .drop_cnt                (drop_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input w_t act, input w_t req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // exp_off < 0: no write is expected from this update (dropped or discarded)
  task automatic push(input logic [8:0] bi, input logic [1:0] sel, input logic inc,
                      input logic dec, input logic bwe, input logic [8:0] ti,
                      input logic [128:0] m, input logic [128:0] d,
                      input logic exp_rdy, input logic exp_stall, input int exp_off);
    exp_t e;
    upd_bht_en    = 1'b1;
    upd_bht_index = bi;
    upd_bht_sel   = sel;
    upd_bht_inc   = inc;
    upd_bht_dec   = dec;
    upd_btb_we    = bwe;
    upd_btb_index = ti;
    upd_btb_wmask = m;
    upd_btb_din   = d;
    #1;
    chk("upd_ready", w_t'(upd_ready), w_t'(exp_rdy));
    if (exp_off >= 0) begin
      e.bidx  = bi;
      e.sel   = sel;
      e.inc   = inc;
      e.dec   = dec;
      e.bwe   = bwe;
      e.tidx  = bwe ? ti : 9'h0;
      e.mask  = bwe ? m : '0;
      e.din   = bwe ? d : '0;
      e.stall = exp_stall;
      e.cyc   = cyc + exp_off;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    upd_bht_en    = 1'b0;
    upd_bht_index = '0;
    upd_bht_sel   = '0;
    upd_bht_inc   = 1'b0;
    upd_bht_dec   = 1'b0;
    upd_btb_we    = 1'b0;
    upd_btb_index = '0;
    upd_btb_wmask = '0;
    upd_btb_din   = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (bht_write_enable) begin
        if (q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_write: actual index %h required no write (cycle %0d)",
                   bht_write_index, cyc);
        end else begin
          e = q.pop_front();
          chk("bht_fields",
              w_t'({bht_write_index, bht_write_counter_select, bht_write_inc, bht_write_dec, bht_valid_in}),
              w_t'({e.bidx, e.sel, e.inc, e.dec, 1'b1}));
          chk("btb_we", w_t'(btb_we), w_t'(e.bwe));
          chk("btb_write_index", w_t'(btb_write_index), w_t'(e.tidx));
          chk("btb_wmask", w_t'(btb_wmask), w_t'(e.mask));
          chk("btb_din", w_t'(btb_din), w_t'(e.din));
          chk("rd_stall", w_t'(ifu_btb_rd_stall), w_t'(e.stall));
          chk("issue_cycle", w_t'(cyc), w_t'(e.cyc));
        end
      end else begin
        chk("idle_outputs",
            w_t'({ifu_btb_rd_stall, btb_we, bht_valid_in, bht_write_index,
                  bht_write_counter_select, bht_write_inc, bht_write_dec, btb_write_index}),
            w_t'(0));
      end
    end
  end

  initial begin : stimulus
    int k;
    junk_m         = {129{1'b1}};
    junk_d         = {1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
    m2             = {1'b1, 64'h0, 32'hFFFF_FFFF, 32'h0};
    d2             = {1'b1, 64'h0, 32'h8000_1000, 32'h0};
    reset_n        = 1'b0;
    ifu_btb_rd_req = 1'b0;
    upd_bht_en     = 1'b0;
    upd_bht_index  = '0;
    upd_bht_sel    = '0;
    upd_bht_inc    = 1'b0;
    upd_bht_dec    = 1'b0;
    upd_btb_we     = 1'b0;
    upd_btb_index  = '0;
    upd_btb_wmask  = '0;
    upd_btb_din    = '0;
    wait_cyc(2);
    chk("reset_outputs", w_t'({bht_write_enable, btb_we, ifu_btb_rd_stall, btb_din}), w_t'(0));
    chk("reset_drop_cnt", w_t'(drop_cnt), w_t'(0));
    chk("reset_upd_ready", w_t'(upd_ready), w_t'(1));
    reset_n = 1'b1;
    wait_cyc(1);

    // BHT-only update; BTB inputs carry junk that must not reach the BTB port
    push(9'h12A, 2'd2, 1'b1, 1'b0, 1'b0, 9'h155, junk_m, junk_d, 1'b1, 1'b0, 1);
    chk("upd_ready_after_bht", w_t'(upd_ready), w_t'(1));
    wait_cyc(3);

    // BTB update with the port free: both writes the next cycle
    push(9'h040, 2'd1, 1'b0, 1'b1, 1'b1, 9'h040, m2, d2, 1'b1, 1'b0, 1);
    wait_cyc(3);

    // Fetch holds the port: 8 blocked cycles, forced write on the 9th
    ifu_btb_rd_req = 1'b1;
    k = cyc;
    push(9'h0AA, 2'd0, 1'b1, 1'b0, 1'b1, 9'h0AB, junk_m, d2, 1'b1, 1'b1, 9);
    while (cyc < k + 10) wait_cyc(1);
    ifu_btb_rd_req = 1'b0;
    wait_cyc(3);

    // Five back-to-back BTB updates against a busy port: fifth is dropped
    ifu_btb_rd_req = 1'b1;
    k = cyc;
    push(9'h001, 2'd0, 1'b1, 1'b0, 1'b1, 9'h011, m2, {1'b1, 128'h1}, 1'b1, 1'b1, 9);
    push(9'h002, 2'd1, 1'b0, 1'b1, 1'b1, 9'h012, m2, {1'b1, 128'h2}, 1'b1, 1'b0, 9);
    push(9'h001, 2'd2, 1'b1, 1'b0, 1'b1, 9'h011, m2, {1'b1, 128'h3}, 1'b1, 1'b0, 9);
    push(9'h004, 2'd3, 1'b0, 1'b1, 1'b1, 9'h014, m2, {1'b1, 128'h4}, 1'b1, 1'b0, 9);
    push(9'h005, 2'd0, 1'b1, 1'b0, 1'b1, 9'h015, m2, {1'b1, 128'h5}, 1'b0, 1'b0, -1);
    chk("drop_cnt_after_overflow", w_t'(drop_cnt), w_t'(1));
    while (cyc < k + 10) wait_cyc(1);
    ifu_btb_rd_req = 1'b0;
    wait_cyc(5);

    // Full FIFO, port released in the same cycle as a push: push accepted
    ifu_btb_rd_req = 1'b1;
    push(9'h101, 2'd1, 1'b1, 1'b0, 1'b1, 9'h021, m2, {1'b1, 128'h11}, 1'b1, 1'b0, 4);
    push(9'h102, 2'd2, 1'b0, 1'b1, 1'b1, 9'h022, m2, {1'b1, 128'h12}, 1'b1, 1'b0, 4);
    push(9'h103, 2'd3, 1'b1, 1'b0, 1'b1, 9'h023, m2, {1'b1, 128'h13}, 1'b1, 1'b0, 4);
    push(9'h104, 2'd0, 1'b0, 1'b1, 1'b1, 9'h024, m2, {1'b1, 128'h14}, 1'b1, 1'b0, 4);
    ifu_btb_rd_req = 1'b0;
    push(9'h105, 2'd1, 1'b1, 1'b0, 1'b0, 9'h1AA, junk_m, junk_d, 1'b1, 1'b0, 4);
    chk("drop_cnt_after_full_push", w_t'(drop_cnt), w_t'(1));
    wait_cyc(6);

    // Reset with three entries queued: nothing may come out, before or after
    ifu_btb_rd_req = 1'b1;
    push(9'h0F1, 2'd1, 1'b1, 1'b0, 1'b1, 9'h031, m2, d2, 1'b1, 1'b0, -1);
    push(9'h0F2, 2'd2, 1'b1, 1'b0, 1'b1, 9'h032, m2, d2, 1'b1, 1'b0, -1);
    push(9'h0F3, 2'd3, 1'b1, 1'b0, 1'b1, 9'h033, m2, d2, 1'b1, 1'b0, -1);
    ifu_btb_rd_req = 1'b0;
    reset_n        = 1'b0;
    #1;
    chk("midreset_outputs",
        w_t'({bht_write_enable, bht_valid_in, btb_we, ifu_btb_rd_stall, bht_write_index, btb_write_index}),
        w_t'(0));
    chk("midreset_btb_din", w_t'(btb_din), w_t'(0));
    chk("midreset_drop_cnt", w_t'(drop_cnt), w_t'(0));
    wait_cyc(2);
    reset_n = 1'b1;
    #1;
    chk("postreset_upd_ready", w_t'(upd_ready), w_t'(1));
    chk("postreset_bht_we", w_t'(bht_write_enable), w_t'(0));
    wait_cyc(5);

    push(9'h1FF, 2'd3, 1'b0, 1'b1, 1'b0, 9'h000, junk_m, junk_d, 1'b1, 1'b0, 1);
    wait_cyc(3);
    chk("scoreboard_drained", w_t'(q.size()), w_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bpu_update_arb.md
Name: bpu_update_arb

Overview:
- Buffers branch-predictor training updates (BHT counter inc/dec plus optional BTB target write) produced each cycle by the branch unit, and drains them to the BHT and BTB write ports.
- The BTB is a single-port SRAM shared with fetch-side reads. Fetch reads have priority; a starvation counter guarantees writes eventually proceed.
- Sits between the branch unit and the BHT/BTB arrays in the frontend.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, ≥2).
- BHTBTB_INDEX_WIDTH, 9, BHT/BTB set index width.
- STARVE_LIMIT, 8, consecutive cycles a head BTB write may be blocked before it is forced.

Ports:
- clock  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- upd_bht_en  in  1  update valid (BHT write request).
- upd_bht_index  in  BHTBTB_INDEX_WIDTH  BHT set.
- upd_bht_sel  in  2  counter select (pc[3:2]).
- upd_bht_inc  in  1  increment.
- upd_bht_dec  in  1  decrement.
- upd_btb_we  in  1  update also carries a BTB write (only meaningful with upd_bht_en).
- upd_btb_index  in  9  BTB set.
- upd_btb_wmask  in  129  BTB bit mask.
- upd_btb_din  in  129  BTB data (valid + 4×32 targets).
- upd_ready  out  1  FIFO can accept this cycle.
- ifu_btb_rd_req  in  1  fetch wants the BTB port this cycle.
- ifu_btb_rd_stall  out  1  fetch read denied this cycle (forced write).
- bht_write_enable  out  1  BHT write.
- bht_write_index  out  BHTBTB_INDEX_WIDTH  BHT write index.
- bht_write_counter_select  out  2  counter select.
- bht_write_inc  out  1  increment.
- bht_write_dec  out  1  decrement.
- bht_valid_in  out  1  equals bht_write_enable.
- btb_we  out  1  BTB write.
- btb_write_index  out  9  BTB write index.
- btb_wmask  out  129  BTB write mask.
- btb_din  out  129  BTB write data.
- drop_cnt  out  32  updates lost because the FIFO was full (PMU).

Behaviour:
- Reset: FIFO empty, pointers 0, starvation counter 0. All outputs 0; upd_ready=1.
- Enqueue: on upd_bht_en & upd_ready, push {bht fields, btb_we, btb fields}. Entries with upd_bht_en=0 are ignored.
- upd_ready = !full | deq_this_cycle. A push to a full FIFO is accepted when the head drains in the same cycle.
- Upstream cannot stall. upd_bht_en while !upd_ready drops the update and increments drop_cnt (wraps at 2^32).
- Head issue is combinational from the head entry, with no same-cycle bypass. An update enqueued in cycle N issues no earlier than N+1.
- Drain rule for a non-empty head:
  - Head btb_we=0: issue the BHT write, dequeue. Not blocked by ifu_btb_rd_req.
  - Head btb_we=1 and !ifu_btb_rd_req: issue BHT and BTB writes in the same cycle, dequeue, clear the starvation counter.
  - Head btb_we=1 and ifu_btb_rd_req: nothing issues, starvation counter +1.
  - When the counter reaches STARVE_LIMIT, the next cycle forces the write: issue both writes, assert ifu_btb_rd_stall=1 for that cycle only, dequeue, clear the counter.
- The starvation counter clears whenever the head changes or the FIFO is empty. It saturates at STARVE_LIMIT.
- ifu_btb_rd_stall is 0 in every cycle except a forced write.
- btb_* outputs are 0 when btb_we=0. bht_* outputs are 0 when bht_write_enable=0.
- Ordering: strictly FIFO. Updates to the same index are never reordered or merged.
- Pointer wrap: log2(DEPTH) pointers plus a wrap bit. full = same index with different wrap bit; empty = equal pointers.
- Simultaneous push and pop while empty: not possible, since no bypass exists; the push lands and pops on a later cycle.
- Reset mid-operation: queued updates are discarded (training loss only, no architectural effect). Outputs drop to 0 asynchronously.

Decomposition:
- Package bpu_pkg:
  - bpu_update_t struct (bht index/sel/inc/dec, btb_we/index/wmask/din).
  - BTB_DATA_W=129.
  - BTB_INDEX_W=9.
- One sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty, async active-low reset).
- The arbitration and starvation FSM (states IDLE, WAIT_PORT, FORCE) stay in bpu_update_arb.

Test Plan:
- Single BHT-only update (index 0x12A, sel 2, inc) in cycle 0, rd_req=0 → cycle 1: bht_write_enable=1, index 0x12A, sel 2, inc=1; upd_ready stays 1.
- BTB update (index 0x040, wmask bit128+[63:32], din target 0x8000_1000 in slot 1) with rd_req=0 → next cycle: btb_we=1, matching mask/data, and the BHT write in the same cycle.
- BTB update with rd_req held high → no write for 8 cycles. Cycle 9 after issue eligibility: forced write, ifu_btb_rd_stall=1 for exactly 1 cycle, then 0.
- Five back-to-back BTB updates with rd_req=1, DEPTH=4 → upd_ready low after 4 pushes, 5th dropped, drop_cnt=1. Subsequently drained in order.
- FIFO full, rd_req=0, push in the same cycle as head dequeue → accepted, drop_cnt unchanged, ordering preserved.
- reset_n pulsed low with 3 entries queued → all outputs 0 immediately; after release, empty, upd_ready=1, no stale writes issued.
